// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmit feeder.
// Register map, register bit positions and sequencer states.
package i2s_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_CLR    = 2;

   localparam int ST_FULL  = 8;
   localparam int ST_EMPTY = 9;
   localparam int ST_UDR   = 10;
   localparam int ST_OVF   = 11;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_t;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous FIFO of stereo pairs; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module i2s_sample_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_push,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_pop,
   output logic [W-1:0]  o_rdata,
   output logic          o_full,
   output logic          o_empty,
   output logic [LW-1:0] o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [LW-1:0] r_level;

   logic w_full;
   logic w_empty;
   logic w_do_push;
   logic w_do_pop;

   assign w_full    = (r_level == LW'(DEPTH));
   assign w_empty   = (r_level == '0);
   assign w_do_pop  = i_pop && !w_empty;
   assign w_do_push = i_push && (!w_full || w_do_pop);

   assign o_rdata = r_mem[r_rd];
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_level = r_level;

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push)
            r_wr <= r_wr + AW'(1);
         if (w_do_pop)
            r_rd <= r_rd + AW'(1);
         if (w_do_push && !w_do_pop)
            r_level <= r_level + LW'(1);
         else if (w_do_pop && !w_do_push)
            r_level <= r_level - LW'(1);
      end
   end

endmodule

// File: rtl/i2s_tx_feeder.sv
// Avalon-MM sample buffer feeding an I2S transmitter; generates
// sck/ws and holds each stereo pair stable for a full frame.
module i2s_tx_feeder
   import i2s_pkg::*;
#(
   parameter int DW      = 8,
   parameter int DEPTH   = 4,
   parameter int CLK_DIV = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    avs_address,
   input  logic          avs_write,
   input  logic [31:0]   avs_writedata,
   input  logic          avs_read,
   output logic [31:0]   avs_readdata,
   output logic          irq,
   output logic          sck,
   output logic          ws,
   output logic [DW-1:0] data_left,
   output logic [DW-1:0] data_right
);

   localparam int LW   = $clog2(DEPTH) + 1;
   localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW   = $clog2(DW);

   seq_state_t r_state;
   seq_state_t w_state_nxt;

   logic            r_en;
   logic            r_irq_en;
   logic            r_udr;
   logic            r_ovf;
   logic            r_irq;
   logic            r_sck;
   logic            r_ws;
   logic            r_started;
   logic [DIVW-1:0] r_div;
   logic [BW-1:0]   r_bit;
   logic [DW-1:0]   r_left;
   logic [DW-1:0]   r_right;
   logic [31:0]     r_rdata;

   logic            w_data_wr;
   logic            w_ctrl_wr;
   logic            w_en_nxt;
   logic            w_adv;
   logic            w_tick;
   logic            w_fall;
   logic            w_wrap;
   logic            w_fs;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic [LW-1:0]   w_level;
   logic [2*DW-1:0] w_fifo_wdata;
   logic [2*DW-1:0] w_fifo_rdata;
   logic [31:0]     w_rdata;
   logic            w_unused;

   assign w_data_wr = avs_write && (avs_address == ADDR_DATA);
   assign w_ctrl_wr = avs_write && (avs_address == ADDR_CTRL);
   assign w_push    = w_data_wr;
   assign w_pop     = w_fs && !w_empty;
   assign w_adv     = (r_state == RUN) && (w_state_nxt == RUN);
   assign w_unused  = ^avs_writedata;

   assign w_fifo_wdata = {avs_writedata[16+DW-1:16],
                          avs_writedata[DW-1:0]};

   i2s_sample_fifo #(
      .W     (2*DW),
      .DEPTH (DEPTH),
      .LW    (LW)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata (w_fifo_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // State follows the enable value that will hold next cycle.
   always_comb begin
      w_en_nxt    = r_en;
      w_state_nxt = r_state;
      w_tick      = 1'b0;
      w_fall      = 1'b0;
      w_wrap      = 1'b0;
      w_fs        = 1'b0;
      if (w_ctrl_wr)
         w_en_nxt = avs_writedata[CTRL_EN];
      unique case (r_state)
         IDLE: begin
            if (w_en_nxt)
               w_state_nxt = RUN;
         end
         RUN: begin
            if (!w_en_nxt)
               w_state_nxt = IDLE;
            w_tick = (r_div == DIVW'(CLK_DIV - 1));
            w_fall = w_tick && r_sck;
            w_wrap = w_fall && (r_bit == BW'(DW - 1));
            w_fs   = !r_started || (w_wrap && r_ws);
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || !w_adv) begin
         r_div     <= '0;
         r_bit     <= '0;
         r_sck     <= 1'b0;
         r_ws      <= 1'b0;
         r_started <= 1'b0;
      end else begin
         r_started <= 1'b1;
         r_div     <= w_tick ? '0 : r_div + DIVW'(1);
         if (w_tick)
            r_sck <= ~r_sck;
         if (w_fall)
            r_bit <= w_wrap ? '0 : r_bit + BW'(1);
         if (w_wrap)
            r_ws <= ~r_ws;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_left  <= '0;
         r_right <= '0;
      end else if (w_fs) begin
         r_left  <= w_pop ? w_fifo_rdata[2*DW-1:DW] : '0;
         r_right <= w_pop ? w_fifo_rdata[DW-1:0] : '0;
      end
   end

   // Set events win over a clear written in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_en     <= 1'b0;
         r_irq_en <= 1'b0;
         r_udr    <= 1'b0;
         r_ovf    <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_en <= w_en_nxt;
         if (w_ctrl_wr)
            r_irq_en <= avs_writedata[CTRL_IRQ_EN];
         if (w_ctrl_wr && avs_writedata[CTRL_CLR]) begin
            r_udr <= 1'b0;
            r_ovf <= 1'b0;
         end
         if (w_fs && w_empty)
            r_udr <= 1'b1;
         if (w_push && w_full && !w_pop)
            r_ovf <= 1'b1;
         r_irq <= r_en && r_irq_en &&
                  (w_level <= LW'(DEPTH / 2));
      end
   end

   always_comb begin
      w_rdata = '0;
      case (avs_address)
         ADDR_CTRL: begin
            w_rdata[CTRL_EN]     = r_en;
            w_rdata[CTRL_IRQ_EN] = r_irq_en;
         end
         ADDR_STATUS: begin
            w_rdata[7:0]     = 8'(w_level);
            w_rdata[ST_FULL]  = w_full;
            w_rdata[ST_EMPTY] = w_empty;
            w_rdata[ST_UDR]   = r_udr;
            w_rdata[ST_OVF]   = r_ovf;
         end
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_rdata <= '0;
      else if (avs_read)
         r_rdata <= w_rdata;
   end

   assign avs_readdata = r_rdata;
   assign irq          = r_irq;
   assign sck          = r_sck;
   assign ws           = r_ws;
   assign data_left    = r_left;
   assign data_right   = r_right;

endmodule

// File: tb/tb_i2s_tx_feeder.sv
// Directed self-checking bench for i2s_tx_feeder
// (DW=8, DEPTH=4, CLK_DIV=2).
module tb_i2s_tx_feeder;

   localparam int DW      = 8;
   localparam int DEPTH   = 4;
   localparam int CLK_DIV = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    avs_address = '0;
   logic          avs_write = 1'b0;
   logic [31:0]   avs_writedata = '0;
   logic          avs_read = 1'b0;
   logic [31:0]   avs_readdata;
   logic          irq;
   logic          sck;
   logic          ws;
   logic [DW-1:0] data_left;
   logic [DW-1:0] data_right;

   int errors = 0;
   int checks = 0;

   i2s_tx_feeder #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .avs_address   (avs_address),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .irq           (irq),
      .sck           (sck),
      .ws            (ws),
      .data_left     (data_left),
      .data_right    (data_right)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      tick(1);
      avs_write     = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      avs_address = a;
      avs_read    = 1'b1;
      tick(1);
      avs_read    = 1'b0;
      d           = avs_readdata;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int bad;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      checks++;
      if ({irq, sck, ws, data_left, data_right} !== '0) begin
         errors++;
         $display("FAIL reset_outs: got %b/%b/%b %h %h want 0",
                  irq, sck, ws, data_left, data_right);
      end
      checks++;
      if (avs_readdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata: got %h want 0", avs_readdata);
      end
      rd(2'd2, d);
      checks++;
      if (d !== 32'h200) begin
         errors++;
         $display("FAIL reset_status: got %h want 200", d);
      end
      rd(2'd0, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL read_data_reg: got %h want 0", d);
      end
      rd(2'd2, d);
      rd(2'd3, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL read_reserved: got %h want 0", d);
      end
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (sck !== 1'b0 || ws !== 1'b0)
            bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL idle_quiet: got %0d active cycles want 0", bad);
      end
   endtask

   task automatic test_basic_frame();
      int sck_r1, sck_r2, ws_rise, ws_fall;
      logic prev;
      logic [7:0] r63, l64, r64;
      sck_r1  = -1;
      sck_r2  = -1;
      ws_rise = -1;
      ws_fall = -1;
      r63 = 'x;
      l64 = 'x;
      r64 = 'x;
      wr(2'd0, 32'h00A5_005A);
      wr(2'd1, 32'h1);
      tick(1);
      checks++;
      if (data_left !== 8'hA5 || data_right !== 8'h5A) begin
         errors++;
         $display("FAIL first_load: got %h/%h want a5/5a",
                  data_left, data_right);
      end
      prev = sck;
      for (int k = 2; k <= 70; k++) begin
         tick(1);
         if (sck && !prev) begin
            if (sck_r1 < 0)
               sck_r1 = k;
            else if (sck_r2 < 0)
               sck_r2 = k;
         end
         prev = sck;
         if (ws && ws_rise < 0)
            ws_rise = k;
         if (!ws && ws_rise >= 0 && ws_fall < 0)
            ws_fall = k;
         if (k == 63)
            r63 = data_right;
         if (k == 64) begin
            l64 = data_left;
            r64 = data_right;
         end
      end
      checks++;
      if (sck_r2 - sck_r1 !== 4) begin
         errors++;
         $display("FAIL sck_period: got %0d want 4", sck_r2 - sck_r1);
      end
      checks++;
      if (ws_rise !== 32) begin
         errors++;
         $display("FAIL ws_rise: got %0d want 32", ws_rise);
      end
      checks++;
      if (ws_fall !== 64) begin
         errors++;
         $display("FAIL ws_fall: got %0d want 64", ws_fall);
      end
      checks++;
      if (r63 !== 8'h5A) begin
         errors++;
         $display("FAIL right_hold: got %h want 5a", r63);
      end
      checks++;
      if (l64 !== 8'h00 || r64 !== 8'h00) begin
         errors++;
         $display("FAIL udr_load: got %h/%h want 00/00", l64, r64);
      end
   endtask

   task automatic test_underrun();
      logic [31:0] d;
      rd(2'd2, d);
      checks++;
      if (d !== 32'h600) begin
         errors++;
         $display("FAIL udr_status: got %h want 600", d);
      end
      wr(2'd1, 32'h5);
      rd(2'd2, d);
      checks++;
      if (d !== 32'h200) begin
         errors++;
         $display("FAIL udr_clear: got %h want 200", d);
      end
      rd(2'd1, d);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL ctrl_read: got %h want 1", d);
      end
      wr(2'd1, 32'h0);
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      wr(2'd0, 32'h0011_0022);
      wr(2'd0, 32'h0033_0044);
      wr(2'd0, 32'h0055_0066);
      wr(2'd0, 32'h0077_0088);
      wr(2'd0, 32'h0099_00AA);
      rd(2'd2, d);
      checks++;
      if (d !== 32'h904) begin
         errors++;
         $display("FAIL ovf_status: got %h want 904", d);
      end
      wr(2'd1, 32'h4);
      rd(2'd2, d);
      checks++;
      if (d !== 32'h104) begin
         errors++;
         $display("FAIL ovf_clear: got %h want 104", d);
      end
   endtask

   task automatic test_simul_push_pop();
      logic [31:0] d;
      wr(2'd1, 32'h1);
      tick(1);
      checks++;
      if ({data_left, data_right} !== 16'h1122) begin
         errors++;
         $display("FAIL order0: got %h%h want 1122",
                  data_left, data_right);
      end
      wr(2'd0, 32'h00BB_00CC);
      tick(61);
      wr(2'd0, 32'h00DD_00EE);
      checks++;
      if ({data_left, data_right} !== 16'h3344) begin
         errors++;
         $display("FAIL order1: got %h%h want 3344",
                  data_left, data_right);
      end
      rd(2'd2, d);
      checks++;
      if (d !== 32'h104) begin
         errors++;
         $display("FAIL pushpop_status: got %h want 104", d);
      end
      tick(63);
      checks++;
      if ({data_left, data_right} !== 16'h5566) begin
         errors++;
         $display("FAIL order2: got %h%h want 5566",
                  data_left, data_right);
      end
      tick(64);
      checks++;
      if ({data_left, data_right} !== 16'h7788) begin
         errors++;
         $display("FAIL order3: got %h%h want 7788",
                  data_left, data_right);
      end
      tick(64);
      checks++;
      if ({data_left, data_right} !== 16'hBBCC) begin
         errors++;
         $display("FAIL order4: got %h%h want bbcc",
                  data_left, data_right);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_masked: got %b want 0", irq);
      end
      tick(64);
      checks++;
      if ({data_left, data_right} !== 16'hDDEE) begin
         errors++;
         $display("FAIL order5: got %h%h want ddee",
                  data_left, data_right);
      end
   endtask

   task automatic test_disable_irq();
      tick(10);
      checks++;
      if (sck !== 1'b1) begin
         errors++;
         $display("FAIL pre_disable_sck: got %b want 1", sck);
      end
      wr(2'd1, 32'h0);
      checks++;
      if (sck !== 1'b0 || ws !== 1'b0) begin
         errors++;
         $display("FAIL disable_clk: got %b/%b want 0/0", sck, ws);
      end
      tick(5);
      checks++;
      if ({sck, data_left, data_right} !== 17'h0DDEE) begin
         errors++;
         $display("FAIL disable_hold: got %b %h%h want 0 ddee",
                  sck, data_left, data_right);
      end
      wr(2'd0, 32'h0001_0002);
      wr(2'd0, 32'h0003_0004);
      wr(2'd0, 32'h0005_0006);
      wr(2'd1, 32'h3);
      tick(2);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_low_water: got %b want 1", irq);
      end
      checks++;
      if ({data_left, data_right} !== 16'h0102) begin
         errors++;
         $display("FAIL reenable_load: got %h%h want 0102",
                  data_left, data_right);
      end
      wr(2'd0, 32'h0007_0008);
      tick(1);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_above_water: got %b want 0", irq);
      end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] d;
      tick(10);
      avs_address   = 2'd0;
      avs_writedata = 32'h0042_0024;
      avs_write     = 1'b1;
      reset         = 1'b1;
      tick(1);
      reset         = 1'b0;
      avs_write     = 1'b0;
      checks++;
      if ({irq, sck, ws, data_left, data_right} !== '0) begin
         errors++;
         $display("FAIL midreset_outs: got %b/%b/%b %h %h want 0",
                  irq, sck, ws, data_left, data_right);
      end
      rd(2'd2, d);
      checks++;
      if (d !== 32'h200) begin
         errors++;
         $display("FAIL midreset_status: got %h want 200", d);
      end
      rd(2'd1, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL midreset_ctrl: got %h want 0", d);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_underrun();
      test_overflow();
      test_simul_push_pop();
      test_disable_irq();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
